// File: rtl/alt_vipitc131_mode_update_ctrl.sv
// Frame-aligned mode update controller: captures a mode word on a trigger pulse, applies it
// at the next frame boundary, then holds off for a settle window before accepting the next apply.
module alt_vipitc131_mode_update_ctrl #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                  sync_clock,
  input  logic                  rst_n,
  input  logic                  trigger_in,
  input  logic [DATA_WIDTH-1:0] mode_in,
  input  logic                  frame_end,
  output logic [DATA_WIDTH-1:0] mode_out,
  output logic                  mode_valid,
  output logic                  update_pulse,
  output logic                  busy,
  output logic                  settle_done,
  output logic [CNT_WIDTH-1:0]  merged_count
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPending, StSettle} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shadow_q;
  logic                  pend_flag_q;
  logic [SettleW-1:0]    settle_cnt_q;
  logic                  cnt_sat;

  assign cnt_sat = &merged_count;

  always_ff @(posedge sync_clock) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      shadow_q     <= '0;
      pend_flag_q  <= 1'b0;
      settle_cnt_q <= '0;
      mode_out     <= '0;
      mode_valid   <= 1'b0;
      update_pulse <= 1'b0;
      busy         <= 1'b0;
      settle_done  <= 1'b0;
      merged_count <= '0;
    end else begin
      update_pulse <= 1'b0;
      settle_done  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // frame_end is deliberately ignored here so an apply never uses a same-cycle boundary
          if (trigger_in) begin
            shadow_q <= mode_in;
            state_q  <= StPending;
            busy     <= 1'b1;
          end
        end
        StPending: begin
          if (frame_end) begin
            mode_out     <= trigger_in ? mode_in : shadow_q;
            update_pulse <= 1'b1;
            mode_valid   <= 1'b1;
            settle_cnt_q <= SettleLoad;
            state_q      <= StSettle;
            busy         <= 1'b1;
            if (trigger_in) begin
              shadow_q <= mode_in;
              if (!cnt_sat) merged_count <= merged_count + CNT_WIDTH'(1);
            end
          end else if (trigger_in) begin
            shadow_q <= mode_in;
            if (!cnt_sat) merged_count <= merged_count + CNT_WIDTH'(1);
          end
        end
        StSettle: begin
          if (trigger_in) begin
            shadow_q    <= mode_in;
            pend_flag_q <= 1'b1;
            if (pend_flag_q && !cnt_sat) merged_count <= merged_count + CNT_WIDTH'(1);
          end
          if (settle_cnt_q != '0) begin
            settle_cnt_q <= settle_cnt_q - SettleW'(1);
          end else begin
            settle_done <= 1'b1;
            // Clearing here overrides the set above; a same-cycle trigger still re-arms
            pend_flag_q <= 1'b0;
            if (pend_flag_q || trigger_in) begin
              state_q <= StPending;
              busy    <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
